// File: rtl/leitor_banco_registradores.sv
// Register bank dump engine: reads a circular range of the bank two
// registers per read cycle and streams them out one word at a time.
module leitor_banco_registradores #(
   parameter int LARGURA_DADO = 16,
   parameter int LARGURA_END  = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    iniciar,
   input  logic [LARGURA_END-1:0]  end_inicial,
   input  logic [LARGURA_END-1:0]  end_final,
   output logic [LARGURA_END-1:0]  endereco_reg1,
   output logic [LARGURA_END-1:0]  endereco_reg2,
   input  logic [LARGURA_DADO-1:0] valor_reg1,
   input  logic [LARGURA_DADO-1:0] valor_reg2,
   output logic [LARGURA_DADO-1:0] saida_dado,
   output logic [LARGURA_END-1:0]  saida_endereco,
   output logic                    saida_valida,
   input  logic                    saida_pronta,
   output logic                    ocupado,
   output logic                    feito
);

   typedef enum logic [2:0] {
      OCIOSO,
      LEITURA,
      ENVIO0,
      ENVIO1,
      FIM
   } estado_t;

   localparam logic [LARGURA_END-1:0] UM   = LARGURA_END'(1);
   localparam logic [LARGURA_END-1:0] DOIS = LARGURA_END'(2);
   localparam logic [LARGURA_END:0]   UM_N   = (LARGURA_END+1)'(1);
   localparam logic [LARGURA_END:0]   DOIS_N = (LARGURA_END+1)'(2);

   logic [1:0]              rst_sinc_q;
   logic                    rst_n;

   estado_t                 estado_q, estado_d;
   logic [LARGURA_END-1:0]  cur_q, cur_d;
   logic [LARGURA_END:0]    rest_q, rest_d;
   logic                    par_q, par_d;
   logic [LARGURA_DADO-1:0] buf0_q, buf0_d;
   logic [LARGURA_DADO-1:0] buf1_q, buf1_d;
   logic [LARGURA_END-1:0]  end0_q, end0_d;
   logic [LARGURA_END-1:0]  end1_q, end1_d;
   logic [LARGURA_END-1:0]  distancia;

   // Reset enters immediately; its release is aligned to the clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_sinc_q <= '0;
      end else begin
         rst_sinc_q <= {rst_sinc_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sinc_q[1];

   // Modular subtraction gives the wrap-around distance for free.
   assign distancia = end_final - end_inicial;

   // State and datapath registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= OCIOSO;
         cur_q    <= '0;
         rest_q   <= '0;
         par_q    <= 1'b0;
         buf0_q   <= '0;
         buf1_q   <= '0;
         end0_q   <= '0;
         end1_q   <= '0;
      end else begin
         estado_q <= estado_d;
         cur_q    <= cur_d;
         rest_q   <= rest_d;
         par_q    <= par_d;
         buf0_q   <= buf0_d;
         buf1_q   <= buf1_d;
         end0_q   <= end0_d;
         end1_q   <= end1_d;
      end
   end

   // Next-state: fetch a pair, emit one or two words, repeat.
   always_comb begin
      estado_d = estado_q;
      cur_d    = cur_q;
      rest_d   = rest_q;
      par_d    = par_q;
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      end0_d   = end0_q;
      end1_d   = end1_q;
      unique case (estado_q)
         OCIOSO: begin
            if (iniciar) begin
               cur_d    = end_inicial;
               rest_d   = {1'b0, distancia} + UM_N;
               estado_d = LEITURA;
            end
         end
         LEITURA: begin
            buf0_d   = valor_reg1;
            buf1_d   = valor_reg2;
            end0_d   = cur_q;
            end1_d   = cur_q + UM;
            par_d    = (rest_q >= DOIS_N);
            estado_d = ENVIO0;
         end
         ENVIO0: begin
            if (saida_pronta) begin
               rest_d = rest_q - UM_N;
               if (par_q) begin
                  estado_d = ENVIO1;
               end else begin
                  estado_d = FIM;
               end
            end
         end
         ENVIO1: begin
            if (saida_pronta) begin
               rest_d = rest_q - UM_N;
               if (rest_d == '0) begin
                  estado_d = FIM;
               end else begin
                  cur_d    = cur_q + DOIS;
                  estado_d = LEITURA;
               end
            end
         end
         FIM: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // Outputs decoded from state; read ports idle at address 0.
   always_comb begin
      endereco_reg1  = '0;
      endereco_reg2  = '0;
      saida_dado     = '0;
      saida_endereco = '0;
      saida_valida   = 1'b0;
      feito          = 1'b0;
      ocupado        = (estado_q != OCIOSO);
      unique case (estado_q)
         LEITURA: begin
            endereco_reg1 = cur_q;
            endereco_reg2 = cur_q + UM;
         end
         ENVIO0: begin
            saida_valida   = 1'b1;
            saida_dado     = buf0_q;
            saida_endereco = end0_q;
         end
         ENVIO1: begin
            saida_valida   = 1'b1;
            saida_dado     = buf1_q;
            saida_endereco = end1_q;
         end
         FIM: begin
            feito = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_leitor_banco_registradores.sv
// Bench for the register bank dump engine: directed and random dumps
// compared against an address/word list built from the range rule.
module tb_leitor_banco_registradores;

   logic        clock = 1'b0;
   logic        reset;
   logic        iniciar;
   logic [2:0]  end_inicial;
   logic [2:0]  end_final;
   logic [2:0]  endereco_reg1;
   logic [2:0]  endereco_reg2;
   logic [15:0] valor_reg1;
   logic [15:0] valor_reg2;
   logic [15:0] saida_dado;
   logic [2:0]  saida_endereco;
   logic        saida_valida;
   logic        saida_pronta;
   logic        ocupado;
   logic        feito;

   logic [15:0] bank [8];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign valor_reg1 = bank[endereco_reg1];
   assign valor_reg2 = bank[endereco_reg2];

   leitor_banco_registradores dut (
      .clock          (clock),
      .reset          (reset),
      .iniciar        (iniciar),
      .end_inicial    (end_inicial),
      .end_final      (end_final),
      .endereco_reg1  (endereco_reg1),
      .endereco_reg2  (endereco_reg2),
      .valor_reg1     (valor_reg1),
      .valor_reg2     (valor_reg2),
      .saida_dado     (saida_dado),
      .saida_endereco (saida_endereco),
      .saida_valida   (saida_valida),
      .saida_pronta   (saida_pronta),
      .ocupado        (ocupado),
      .feito          (feito)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic banco_linear(input int mult);
      for (int i = 0; i < 8; i++) bank[i] = 16'(i * mult);
      bank[0] = '0;
   endtask

   // modo: 0 pronta=1, 1 pattern 0,0,1, 2 random.
   // perturba: hold iniciar and scramble range during the dump.
   // aborta: stream address at which reset is pulled (-1 = never).
   task automatic run_dump(input logic [2:0] s, input logic [2:0] e,
                           input int modo, input bit perturba,
                           input int aborta);
      logic [18:0] esp[$];
      logic [5:0]  lp[$];
      logic [18:0] ant;
      logic [19:0] esperado;
      logic [5:0]  lesp;
      int ini, fin, n, cyc, nval;
      bit ant_stall, fim, visto;
      ini = int'(s);
      fin = int'(e);
      n = (fin - ini + 8) % 8 + 1;
      for (int i = 0; i < n; i++) begin
         esp.push_back({3'((ini + i) % 8), bank[(ini + i) % 8]});
      end
      for (int p = 0; p < (n + 1) / 2; p++) begin
         lp.push_back({3'((ini + 2 * p) % 8), 3'((ini + 2 * p + 1) % 8)});
      end
      @(negedge clock);
      iniciar = 1'b1;
      end_inicial = s;
      end_final = e;
      saida_pronta = 1'b1;
      @(negedge clock);
      if (!perturba) iniciar = 1'b0;
      chk("ocupado_sobe", 32'(ocupado), 32'd1);
      cyc = 1;
      nval = 0;
      ant_stall = 0;
      fim = 0;
      visto = 0;
      ant = '0;
      while (!fim && cyc < 300) begin
         if (perturba) {end_inicial, end_final} = 6'($urandom);
         if ({endereco_reg1, endereco_reg2} != 6'd0) begin
            lesp = (lp.size() > 0) ? lp.pop_front() : 6'h3f;
            chk("porta_leitura", 32'({endereco_reg1, endereco_reg2}),
                32'(lesp));
         end
         if (cyc == 1) chk("leitura_sem_valida", 32'(saida_valida), 32'd0);
         if (saida_valida && !visto) begin
            visto = 1;
            chk("latencia", 32'(cyc), 32'd2);
         end
         if (ant_stall) begin
            chk("estavel", 32'({saida_valida, saida_endereco, saida_dado}),
                32'({1'b1, ant}));
         end
         if (aborta >= 0 && saida_valida && int'(saida_endereco) == aborta) begin
            iniciar = 1'b0;
            reset = 1'b0;
            #1;
            chk("reset_async", 32'({saida_valida, ocupado, feito, saida_endereco,
                endereco_reg1, endereco_reg2}), 32'd0);
            chk("reset_dado", 32'(saida_dado), 32'd0);
            repeat (3) begin
               @(negedge clock);
               chk("sem_feito", 32'({feito, ocupado, saida_valida}), 32'd0);
            end
            reset = 1'b1;
            repeat (4) @(negedge clock);
            return;
         end
         if (modo == 0) saida_pronta = 1'b1;
         else if (modo == 1) saida_pronta = saida_valida ? (nval % 3 == 2) : 1'b1;
         else saida_pronta = 1'($urandom);
         if (saida_valida) begin
            nval++;
            if (saida_pronta) begin
               esperado = (esp.size() > 0) ? {1'b1, esp.pop_front()} : 20'h0;
               chk("palavra", 32'({1'b1, saida_endereco, saida_dado}),
                   32'(esperado));
               ant_stall = 0;
            end else begin
               ant_stall = 1;
               ant = {saida_endereco, saida_dado};
            end
         end else begin
            ant_stall = 0;
         end
         if (feito) begin
            fim = 1;
            chk("fila_vazia", 32'(esp.size()), 32'd0);
            chk("portas_usadas", 32'(lp.size()), 32'd0);
            chk("ocupado_em_fim", 32'(ocupado), 32'd1);
            if (modo == 0) begin
               chk("ciclos", 32'(cyc), 32'(1 + 3 * (n / 2) + 2 * (n % 2)));
            end
         end
         @(negedge clock);
         cyc++;
      end
      chk("terminou", 32'(fim), 32'd1);
      iniciar = 1'b0;
      chk("ocupado_desce", 32'({ocupado, feito}), 32'd0);
      repeat (3) begin
         @(negedge clock);
         chk("sem_segundo", 32'({ocupado, saida_valida, feito}), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b0;
      iniciar = 1'b0;
      end_inicial = '0;
      end_final = '0;
      saida_pronta = 1'b0;
      banco_linear(1);
      repeat (2) @(negedge clock);
      chk("reset_saidas", 32'({saida_valida, ocupado, feito, saida_endereco,
          endereco_reg1, endereco_reg2}), 32'd0);
      chk("reset_dado", 32'(saida_dado), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      chk("ocioso", 32'(ocupado), 32'd0);

      run_dump(3'd0, 3'd7, 0, 0, -1);
      run_dump(3'd2, 3'd4, 0, 0, -1);
      banco_linear(16);
      run_dump(3'd6, 3'd1, 0, 0, -1);
      run_dump(3'd3, 3'd3, 0, 0, -1);
      banco_linear(1);
      run_dump(3'd0, 3'd7, 1, 0, -1);
      run_dump(3'd0, 3'd7, 0, 1, -1);
      run_dump(3'd0, 3'd7, 0, 0, 5);
      run_dump(3'd0, 3'd1, 0, 0, -1);

      for (int k = 0; k < 20; k++) begin
         for (int i = 1; i < 8; i++) bank[i] = 16'($urandom);
         bank[0] = '0;
         run_dump(3'($urandom), 3'($urandom), int'($urandom_range(0, 2)),
                  ($urandom % 4) == 0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/leitor_banco_registradores.md
Name: leitor_banco_registradores

Overview:
Debug/dump engine on the read side of the 8 x 16-bit register bank. On a start pulse it drives the bank's two combinational read ports to fetch a register range two registers per read cycle. It buffers each pair locally and streams the words out one at a time over a valid/ready interface, for example to a UART or trace port. It never writes the bank; it is the bank's reader counterpart.

Parameters:
LARGURA_DADO, 16, width of register words
LARGURA_END, 3, register address width (bank depth = 2^LARGURA_END = 8)

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start pulse; sampled only in OCIOSO
end_inicial  input  3  first register of the range; latched on an accepted iniciar
end_final  input  3  last register of the range, inclusive; latched on an accepted iniciar
endereco_reg1  output  3  bank read port 1 address
endereco_reg2  output  3  bank read port 2 address
valor_reg1  input  16  bank read data 1, combinational from endereco_reg1
valor_reg2  input  16  bank read data 2, combinational from endereco_reg2
saida_dado  output  16  streamed register value
saida_endereco  output  3  address of the register carried in saida_dado
saida_valida  output  1  stream valid
saida_pronta  input  1  stream ready from the consumer
ocupado  output  1  high from an accepted iniciar until feito
feito  output  1  one-cycle pulse after the last word is transferred

Behaviour:
- Reset (reset=0, asynchronous) forces: state OCIOSO, all outputs 0, buffer cleared, counters 0. The deassertion of reset is synchronized internally.
- Range length N = ((end_final - end_inicial) mod 8) + 1, giving 1..8 words. end_final < end_inicial wraps through 7 to 0. For example, 6 to 1 streams 6,7,0,1 (N=4). Equal start and end gives N=1.
- States:
  - OCIOSO: waits for iniciar. On iniciar, latch the range, set cur=end_inicial and rest=N, then go to LEITURA. ocupado rises in the same edge.
  - LEITURA (1 cycle): endereco_reg1=cur, endereco_reg2=(cur+1) mod 8. At the end of the cycle, capture valor_reg1/valor_reg2 into buf0/buf1 with their addresses. Set par=2 if rest>=2, otherwise par=1. Go to ENVIO0.
  - ENVIO0: saida_valida=1, saida_dado=buf0, saida_endereco=its address. On valida&&pronta, decrement rest. If par=2, go to ENVIO1. Otherwise, if rest becomes 0, go to FIM.
  - ENVIO1: same as ENVIO0 but for buf1. On transfer, if rest=0 go to FIM. Otherwise set cur=(cur+2) mod 8 and go to LEITURA.
  - FIM (1 cycle): feito=1, ocupado=1. Then go to OCIOSO with ocupado=0.
- Read-port addresses are 0 in every state other than LEITURA.
- Handshake: a transfer happens on any rising edge with valida=1 and pronta=1. While valida=1 and pronta=0, saida_dado and saida_endereco hold stable and valida stays high. valida never drops without a transfer. pronta is ignored when valida=0.
- Latency: iniciar sampled at edge k, LEITURA during cycle k+1, first saida_valida in cycle k+2. With pronta held at 1 the throughput is 2 words per 3 cycles. The full 8-register dump takes 12 stream cycles after the first LEITURA, and feito occurs in the cycle after the last transfer.
- Simultaneous events: iniciar while ocupado=1 (including the FIM cycle) is ignored. Range inputs are sampled only on an accepted iniciar, so later changes have no effect.
- Odd N: the final pair fetch still drives endereco_reg2, but buf1 is discarded and never emitted.
- Reset mid-operation: the stream aborts immediately, valida=0 and ocupado=0, with no feito pulse. The next iniciar restarts cleanly.
- Register 0 is read like any other register; the bank guarantees it reads 0.

Test Plan:
- Reset then full dump: bank holds r_i=i except r0=0, range 0 to 7, pronta=1 -> 8 words (0,0),(1,1)...(7,7) in order. The first valida comes 2 cycles after iniciar, feito pulses once, and ocupado falls the cycle after feito.
- Odd range: range 2 to 4 with bank r_i=i -> words (2,2),(3,3),(4,4) only. Read ports show addresses (2,3) then (4,5), and buf1=5 is never emitted.
- Wrap range: range 6 to 1 with bank r_i=16*i -> stream addresses 6,7,0,1 with data 96,112,0,16. Range 3 to 3 -> a single word (3,48).
- Backpressure: pronta toggles 0,0,1 repeating during the 0 to 7 dump -> saida_dado and saida_endereco stay stable while stalled, there are no duplicated or dropped words, and all 8 words arrive in order.
- iniciar reasserted while ocupado, and range inputs changed mid-dump -> the ongoing stream is unaffected and there is no second dump.
- reset pulled low during ENVIO1 of the pair (4,5) -> outputs are 0 asynchronously and there is no feito. After release, a new iniciar with range 0 to 1 streams (0,0),(1,1).
